// File: rtl/vga_pkg.sv
// Shared VGA timing defaults, RGB pixel type and reader state encoding.
package vga_pkg;

    localparam int unsigned VGA_H_ACTIVE = 640;
    localparam int unsigned VGA_H_FP     = 16;
    localparam int unsigned VGA_H_SYNC   = 96;
    localparam int unsigned VGA_H_BP     = 48;
    localparam int unsigned VGA_V_ACTIVE = 480;
    localparam int unsigned VGA_V_FP     = 10;
    localparam int unsigned VGA_V_SYNC   = 2;
    localparam int unsigned VGA_V_BP     = 33;

    localparam int unsigned VGA_H_TOTAL = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
    localparam int unsigned VGA_V_TOTAL = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    typedef enum logic {
        WAIT_FILL,
        RUN
    } state_t;

endpackage

// File: rtl/vga_fifo_reader_if.sv
// Pixel-side read handshake of the display FIFO.
interface vga_fifo_reader_if;

    logic          rd_fifo;
    logic          fifo_empty;
    vga_pkg::rgb_t fifo_data;

    modport master (output rd_fifo, input fifo_empty, input fifo_data);
    modport slave  (input rd_fifo, output fifo_empty, output fifo_data);

endinterface

// File: rtl/vga_timing_gen.sv
// Horizontal/vertical raster counters with combinational active and sync decode.
module vga_timing_gen #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter int unsigned HW       = $clog2(H_ACTIVE + H_FP + H_SYNC + H_BP),
    parameter int unsigned VW       = $clog2(V_ACTIVE + V_FP + V_SYNC + V_BP)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    output logic [HW-1:0] h_cnt,
    output logic [VW-1:0] v_cnt,
    output logic          act,
    output logic          hs0,
    output logic          vs0
);

    localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned HS_START = H_ACTIVE + H_FP;
    localparam int unsigned HS_END   = HS_START + H_SYNC;
    localparam int unsigned VS_START = V_ACTIVE + V_FP;
    localparam int unsigned VS_END   = VS_START + V_SYNC;

    logic [31:0] h_ext;
    logic [31:0] v_ext;

    always_ff @(posedge clk) begin
        if (!rst) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (en) begin
            if (h_cnt == HW'(H_TOTAL - 1)) begin
                h_cnt <= '0;
                v_cnt <= (v_cnt == VW'(V_TOTAL - 1)) ? '0 : v_cnt + VW'(1);
            end else begin
                h_cnt <= h_cnt + HW'(1);
            end
        end
    end

    // Decode in 32 bits so a zero-width back porch cannot truncate the sync end bound.
    always_comb begin
        h_ext = 32'(h_cnt);
        v_ext = 32'(v_cnt);
        act   = (h_ext < H_ACTIVE) && (v_ext < V_ACTIVE);
        hs0   = !((h_ext >= HS_START) && (h_ext < HS_END));
        vs0   = !((v_ext >= VS_START) && (v_ext < VS_END));
    end

endmodule

// File: rtl/vga_fifo_reader.sv
// VGA raster reader: pops the pixel FIFO during active video and aligns data with sync.
module vga_fifo_reader
    import vga_pkg::*;
#(
    parameter int unsigned H_ACTIVE = VGA_H_ACTIVE,
    parameter int unsigned H_FP     = VGA_H_FP,
    parameter int unsigned H_SYNC   = VGA_H_SYNC,
    parameter int unsigned H_BP     = VGA_H_BP,
    parameter int unsigned V_ACTIVE = VGA_V_ACTIVE,
    parameter int unsigned V_FP     = VGA_V_FP,
    parameter int unsigned V_SYNC   = VGA_V_SYNC,
    parameter int unsigned V_BP     = VGA_V_BP
) (
    input  logic                     clk,
    input  logic                     rst,
    vga_fifo_reader_if.master        fifo,
    output logic                     hsync,
    output logic                     vsync,
    output logic                     de,
    output logic [7:0]               pixel_r,
    output logic [7:0]               pixel_g,
    output logic [7:0]               pixel_b,
    output logic                     frame_start,
    output logic                     underflow
);

    localparam int unsigned HW = $clog2(H_ACTIVE + H_FP + H_SYNC + H_BP);
    localparam int unsigned VW = $clog2(V_ACTIVE + V_FP + V_SYNC + V_BP);

    state_t        state_q;
    state_t        state_d;
    logic [HW-1:0] h_cnt;
    logic [VW-1:0] v_cnt;
    logic          act;
    logic          hs0;
    logic          vs0;
    logic          run;
    logic          rd_q;
    rgb_t          pix;

    assign run = (state_q == RUN);

    vga_timing_gen #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP),
        .HW       (HW),
        .VW       (VW)
    ) u_timing (
        .clk   (clk),
        .rst   (rst),
        .en    (run),
        .h_cnt (h_cnt),
        .v_cnt (v_cnt),
        .act   (act),
        .hs0   (hs0),
        .vs0   (vs0)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= WAIT_FILL;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            WAIT_FILL: if (!fifo.fifo_empty) state_d = RUN;
            RUN:       state_d = RUN;
            default:   state_d = WAIT_FILL;
        endcase
    end

    assign fifo.rd_fifo = run && act && !fifo.fifo_empty;

    always_ff @(posedge clk) begin
        if (!rst) begin
            hsync       <= 1'b1;
            vsync       <= 1'b1;
            de          <= 1'b0;
            rd_q        <= 1'b0;
            frame_start <= 1'b0;
            underflow   <= 1'b0;
        end else begin
            hsync       <= run ? hs0 : 1'b1;
            vsync       <= run ? vs0 : 1'b1;
            de          <= run && act;
            rd_q        <= fifo.rd_fifo;
            frame_start <= run && act && (h_cnt == '0) && (v_cnt == '0);
            underflow   <= underflow || (run && act && fifo.fifo_empty);
        end
    end

    // FIFO dout already lags the read by one cycle, so muxing it here lines it up with de.
    assign pix     = rd_q ? fifo.fifo_data : '0;
    assign pixel_r = pix.r;
    assign pixel_g = pix.g;
    assign pixel_b = pix.b;

endmodule

// File: tb/tb_vga_fifo_reader.sv
// Randomised and directed bench for vga_fifo_reader with a raster-position reference model.
module tb_vga_fifo_reader;

    localparam int unsigned HA = 8;
    localparam int unsigned HF = 2;
    localparam int unsigned HS = 3;
    localparam int unsigned HB = 2;
    localparam int unsigned VA = 4;
    localparam int unsigned VF = 1;
    localparam int unsigned VS = 2;
    localparam int unsigned VB = 1;
    localparam int unsigned HT = HA + HF + HS + HB;
    localparam int unsigned VT = VA + VF + VS + VB;

    logic       clk;
    logic       rst;
    logic       hsync, vsync, de, frame_start, underflow;
    logic [7:0] pixel_r, pixel_g, pixel_b;
    logic [23:0] nxt;

    int n_pass = 0;
    int n_total = 0;

    vga_fifo_reader_if fifo_if ();

    vga_fifo_reader #(
        .H_ACTIVE (HA), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
        .V_ACTIVE (VA), .V_FP (VF), .V_SYNC (VS), .V_BP (VB)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .fifo        (fifo_if.master),
        .hsync       (hsync),
        .vsync       (vsync),
        .de          (de),
        .pixel_r     (pixel_r),
        .pixel_g     (pixel_g),
        .pixel_b     (pixel_b),
        .frame_start (frame_start),
        .underflow   (underflow)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // FIFO dout model: each accepted read presents the next value of an incrementing sequence.
    always @(posedge clk) begin
        if (!rst) begin
            nxt               <= 24'd1;
            fifo_if.fifo_data <= '0;
        end else if (fifo_if.rd_fifo) begin
            fifo_if.fifo_data <= nxt;
            nxt               <= nxt + 24'd1;
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, got, exp, $time);
    endtask

    function automatic logic [23:0] pix();
        return {pixel_r, pixel_g, pixel_b};
    endfunction

    // Reference model: raster position is just the number of cycles spent running.
    bit          m_run = 0;
    int unsigned m_t = 0;
    bit          e_hs = 1, e_vs = 1, e_de = 0, e_fs = 0, e_uf = 0, e_rdprev = 0;

    always @(negedge clk) begin
        int unsigned h, v;
        bit a, e_rd;
        h    = m_t % HT;
        v    = (m_t / HT) % VT;
        a    = (h < HA) && (v < VA);
        e_rd = m_run && a && !fifo_if.fifo_empty;
        chk("rd_fifo", 32'(fifo_if.rd_fifo), 32'(e_rd));
        chk("hsync", 32'(hsync), 32'(e_hs));
        chk("vsync", 32'(vsync), 32'(e_vs));
        chk("de", 32'(de), 32'(e_de));
        chk("frame_start", 32'(frame_start), 32'(e_fs));
        chk("underflow", 32'(underflow), 32'(e_uf));
        chk("pixel", 32'(pix()), e_rdprev ? 32'(fifo_if.fifo_data) : 32'd0);
        if (!rst) begin
            m_run = 0; m_t = 0;
            e_hs = 1; e_vs = 1; e_de = 0; e_fs = 0; e_uf = 0; e_rdprev = 0;
        end else begin
            e_hs     = m_run ? !(h >= HA + HF && h < HA + HF + HS) : 1'b1;
            e_vs     = m_run ? !(v >= VA + VF && v < VA + VF + VS) : 1'b1;
            e_de     = m_run && a;
            e_fs     = m_run && a && h == 0 && v == 0;
            e_uf     = e_uf || (m_run && a && fifo_if.fifo_empty);
            e_rdprev = e_rd;
            if (m_run) m_t++;
            else if (!fifo_if.fifo_empty) m_run = 1;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int rd_cnt, de_cnt, hs_low, vs_low, fs_cnt, fs0, fs1, fs2, errs, run_len, run_min, run_max;
        logic [23:0] seq;

        // Reset hold with data available.
        rst = 1'b0;
        fifo_if.fifo_empty = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("rst_hsync", 32'(hsync), 32'd1);
        chk("rst_vsync", 32'(vsync), 32'd1);
        chk("rst_de", 32'(de), 32'd0);
        chk("rst_rd", 32'(fifo_if.rd_fifo), 32'd0);
        chk("rst_pixel", 32'(pix()), 32'd0);
        rst = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("run_first_rd", 32'(fifo_if.rd_fifo), 32'd1);

        // Wait for FIFO fill.
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        fifo_if.fifo_empty = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("wf_rd", 32'(fifo_if.rd_fifo), 32'd0);
            chk("wf_sync", 32'({hsync, vsync}), 32'd3);
            @(posedge clk); #1;
        end
        fifo_if.fifo_empty = 1'b0;
        @(negedge clk);
        chk("wf_last_idle", 32'(fifo_if.rd_fifo), 32'd0);
        @(posedge clk); #1;

        // Two clean frames: timing counts and data alignment.
        rd_cnt = 0; de_cnt = 0; hs_low = 0; vs_low = 0; fs_cnt = 0; fs0 = -1; fs1 = -1;
        errs = 0; run_len = 0; run_min = 999; run_max = 0; seq = 24'd1;
        for (int i = 0; i < 240; i++) begin
            @(negedge clk);
            if (i == 0) begin
                chk("first_rd", 32'(fifo_if.rd_fifo), 32'd1);
                chk("first_de_lag", 32'(de), 32'd0);
            end
            if (i == 1) begin
                chk("first_de", 32'(de), 32'd1);
                chk("first_pixel", 32'(pix()), 32'h000001);
            end
            rd_cnt += int'(fifo_if.rd_fifo);
            de_cnt += int'(de);
            vs_low += int'(!vsync);
            if (!hsync) begin
                hs_low++; run_len++;
            end else if (run_len != 0) begin
                if (run_len < run_min) run_min = run_len;
                if (run_len > run_max) run_max = run_len;
                run_len = 0;
            end
            if (frame_start) begin
                if (fs_cnt == 0) fs0 = i; else fs1 = i;
                fs_cnt++;
            end
            if (de) begin
                if (pix() != seq) errs++;
                seq++;
            end else if (pix() != 24'd0) begin
                errs++;
            end
            @(posedge clk); #1;
        end
        chk("rd_per_2frames", 32'(rd_cnt), 32'd64);
        chk("de_per_2frames", 32'(de_cnt), 32'd64);
        chk("hs_low_cycles", 32'(hs_low), 32'd48);
        chk("hs_pulse_min", 32'(run_min), 32'd3);
        chk("hs_pulse_max", 32'(run_max), 32'd3);
        chk("vs_low_cycles", 32'(vs_low), 32'd60);
        chk("fs_count", 32'(fs_cnt), 32'd2);
        chk("fs_first", 32'(fs0), 32'd1);
        chk("fs_period", 32'(fs1 - fs0), 32'd120);
        chk("data_seq_errs", 32'(errs), 32'd0);

        // Underflow on visible pixels 3-4 of line 0, then two more frames.
        fs_cnt = 0; fs0 = -1; fs1 = -1; fs2 = -1;
        for (int k = 0; k < 360; k++) begin
            fifo_if.fifo_empty = (k == 3 || k == 4);
            @(negedge clk);
            if (k == 3 || k == 4) chk("uf_no_rd", 32'(fifo_if.rd_fifo), 32'd0);
            if (k == 3) chk("uf_before", 32'(pix()), 32'd67);
            if (k == 4 || k == 5) begin
                chk("uf_black_de", 32'(de), 32'd1);
                chk("uf_black", 32'(pix()), 32'd0);
            end
            if (k == 5) chk("uf_set", 32'(underflow), 32'd1);
            if (k == 6) chk("uf_resume", 32'(pix()), 32'd68);
            if (frame_start) begin
                if (fs_cnt == 0) fs0 = k; else if (fs_cnt == 1) fs1 = k; else fs2 = k;
                fs_cnt++;
            end
            @(posedge clk); #1;
        end
        @(negedge clk);
        chk("uf_sticky", 32'(underflow), 32'd1);
        chk("uf_fs_count", 32'(fs_cnt), 32'd3);
        chk("uf_fs_pos", 32'(fs0), 32'd1);
        chk("uf_fs_period1", 32'(fs1 - fs0), 32'd120);
        chk("uf_fs_period2", 32'(fs2 - fs1), 32'd120);
        @(posedge clk); #1;

        // Random FIFO occupancy with rare resets; the model checks every cycle.
        for (int k = 0; k < 600; k++) begin
            fifo_if.fifo_empty = ($urandom_range(0, 3) == 0);
            rst = ($urandom_range(0, 249) != 0);
            @(posedge clk); #1;
        end

        // Reset mid-frame at v_cnt=2, h_cnt=5.
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        fifo_if.fifo_empty = 1'b0;
        @(posedge clk); #1;
        for (int k = 0; k <= 35; k++) begin
            fifo_if.fifo_empty = (k == 1);
            if (k == 35) rst = 1'b0;
            @(negedge clk);
            if (k == 35) chk("mid_uf_before", 32'(underflow), 32'd1);
            @(posedge clk); #1;
        end
        rst = 1'b1;
        fifo_if.fifo_empty = 1'b1;
        @(negedge clk);
        chk("mid_sync", 32'({hsync, vsync}), 32'd3);
        chk("mid_de", 32'(de), 32'd0);
        chk("mid_uf_clr", 32'(underflow), 32'd0);
        chk("mid_pixel", 32'(pix()), 32'd0);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            @(negedge clk);
            chk("mid_wait_fill", 32'(fifo_if.rd_fifo), 32'd0);
        end
        fifo_if.fifo_empty = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("mid_restart_rd", 32'(fifo_if.rd_fifo), 32'd1);
        @(posedge clk); #1;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/vga_fifo_reader.md
Name: vga_fifo_reader

Overview:
- Read-side consumer of the cross-clock pixel FIFO; runs in the 25 MHz pixel domain.
- Generates VGA raster timing (hsync/vsync/data-enable) and issues FIFO read strobes during active video.
- Aligns the 24-bit FIFO output with the delayed sync signals and blanks the output on underflow.
- Drives the pixel-side handshake (rd_fifo out, fifo_empty in) of the display FIFO path.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync pulse width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BP, 33, vertical back porch (lines)

Ports:
- clk  in  1  pixel clock (25 MHz)
- rst  in  1  synchronous, active-low reset
- fifo_empty  in  1  FIFO empty flag, read-clock domain
- fifo_data  in  24  FIFO dout {R[23:16],G[15:8],B[7:0]}; valid one cycle after an accepted read
- rd_fifo  out  1  FIFO read enable
- hsync  out  1  horizontal sync, active-low
- vsync  out  1  vertical sync, active-low
- de  out  1  data enable, high on visible pixels
- pixel_r  out  8  red channel
- pixel_g  out  8  green channel
- pixel_b  out  8  blue channel
- frame_start  out  1  one-cycle pulse, aligned with first visible pixel of each frame
- underflow  out  1  sticky flag: a visible pixel found the FIFO empty

Behaviour:
- Reset (rst=0 sampled at the clk edge):
  - Outputs: hsync=1, vsync=1, de=0, rd_fifo=0, pixels=0, frame_start=0, underflow=0.
  - Counters h_cnt=0, v_cnt=0; state=WAIT_FILL.
- Reset mid-frame aborts immediately; the frame restarts from WAIT_FILL.
- Widths:
  - H_TOTAL = sum of the H_* parameters (800 by default).
  - V_TOTAL = sum of the V_* parameters (525 by default).
  - Counter widths are $clog2(TOTAL).
- State machine:
  - WAIT_FILL: counters held at 0, all outputs in reset values. Moves to RUN on the first cycle with fifo_empty=0.
  - RUN: h_cnt increments every cycle and wraps from H_TOTAL-1 to 0. On wrap, v_cnt increments, wrapping from V_TOTAL-1 to 0. RUN never returns to WAIT_FILL except via reset.
- Stage-0 timing, combinational from the counters:
  - act = (h_cnt < H_ACTIVE) && (v_cnt < V_ACTIVE).
  - hs0 low when H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC.
  - vs0 low when V_ACTIVE+V_FP <= v_cnt < V_ACTIVE+V_FP+V_SYNC.
- Read strobe:
  - rd_fifo = RUN && act && !fifo_empty. This is combinational, so the FIFO samples it at the same edge.
  - rd_fifo is never asserted during blanking or in WAIT_FILL.
- Output pipeline, one register stage (latency 1 from counter state to outputs):
  - hsync, vsync, de are the registered hs0, vs0, act.
  - Pixels = fifo_data when the previous cycle's rd_fifo was 1, else 0x000000 (black).
  - Sync outputs and pixel data are therefore cycle-aligned.
- Underflow:
  - Trigger: act=1 with fifo_empty=1.
  - That pixel is output black and no read is issued; the raster does not stall.
  - underflow is set and stays set until reset.
- frame_start = registered (act && h_cnt==0 && v_cnt==0).
- Counter wrap at H_TOTAL-1/V_TOTAL-1 on the same cycle: both wrap to 0 and the next frame begins seamlessly.

Decomposition:
- Shared package vga_pkg holds:
  - the default timing constants (H_*, V_*, H_TOTAL, V_TOTAL);
  - the 24-bit RGB pixel type, with field slices R/G/B;
  - the state encoding {WAIT_FILL, RUN}.
- One sub-module, vga_timing_gen:
  - contains the h/v counters and the combinational act/hs0/vs0 decode, with an enable input driven by RUN.
  - The top level adds the read strobe, data pipeline, underflow flag and frame_start.

Test Plan:
- Reset hold: rst=0 for 5 cycles with fifo_empty=0 -> all outputs at reset values, rd_fifo=0; after release, RUN on the next edge and rd_fifo=1 in the same cycle.
- Wait fill: release reset with fifo_empty=1 for 20 cycles -> hsync=vsync=1, rd_fifo=0 throughout; fifo_empty falls -> counting starts, first de=1 one cycle after the first rd_fifo.
- Timing (small parameters H_ACTIVE=8,H_FP=2,H_SYNC=3,H_BP=2,V_ACTIVE=4,V_FP=1,V_SYNC=2,V_BP=1):
  - H_TOTAL=15: hsync low for exactly 3 cycles starting at h_cnt=10 (+1 latency).
  - V_TOTAL=8: vsync low for exactly 2 lines.
  - 32 rd_fifo pulses per frame; frame_start every 120 cycles.
- Data alignment: FIFO model returns incrementing values 0x000001.. -> pixel_{r,g,b} equal the sequence only while de=1, in order, and are 0 while de=0.
- Underflow: force fifo_empty=1 for visible pixels 3-4 of line 0 -> no read on those cycles, those two output pixels 0x000000, underflow=1 and still set after 2 further frames, raster period unchanged.
- Reset mid-frame: assert rst at v_cnt=2, h_cnt=5 -> next cycle outputs at reset values, underflow cleared, state=WAIT_FILL.
